mem_access: RTL and testbench

Memory-access pipeline stage, directly downstream of the execute stage. Registers the execute-stage packet, performs data-memory loads and stores over a req/ack handshake, and aligns and sign-extends load data. Forwards a write-back packet and raises a stall while an access is outstanding.

---
 rtl/mem_access.sv | 187 ++++++++++++++++++
 tb/tb_mem_access.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: registers the execute packet, runs data-memory loads/stores
// over a req/ack handshake, aligns load data. Optional misalignment trap: AKARIN_MISALIGN_TRAP_EN.
package mem_access_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            memRd;
    logic            memWr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] wdata;
  } ex_aux_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst32;
    logic            instValid;
    logic [4:0]      destReg;
    logic [XLEN-1:0] res;
    ex_aux_t         aux;
  } ex2memPkt;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst32;
    logic            instValid;
    logic [4:0]      destReg;
    logic [XLEN-1:0] res;
    logic            excMisalign;
  } mem2wbPkt;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  ex2memPkt        ex2mem_i,
  output mem2wbPkt        mem2wb_o,
  output logic            mem_stall_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t          state_q, state_d;
  ex2memPkt        ex_q;
  logic [XLEN-1:0] load_q;
  logic            is_mem, fault, memop;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, raw, load_res;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // input register, frozen by the pipeline stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ex_q <= '0;
    else if (!stall_i) ex_q <= ex2mem_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          load_q <= '0;
    else if (dmem_ack) load_q <= dmem_rdata;
  end

  assign is_mem = ex_q.instValid & (ex_q.aux.memRd | ex_q.aux.memWr);

`ifdef AKARIN_MISALIGN_TRAP_EN
  always_comb begin
    fault = 1'b0;
    if (is_mem) begin
      case (ex_q.aux.funct3[1:0])
        2'b01:   fault = ex_q.res[0];
        2'b10:   fault = |ex_q.res[1:0];
        default: fault = 1'b0;
      endcase
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign memop = is_mem & ~fault;

  // handshake FSM; HOLD keeps a completed access from being reissued under an external stall
  always_comb begin
    state_d     = state_q;
    dmem_req    = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            state_d = stall_i ? HOLD : IDLE;
          end else begin
            state_d     = BUSY;
            mem_stall_o = 1'b1;
          end
        end
      end
      BUSY: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_d = stall_i ? HOLD : IDLE;
        else          mem_stall_o = 1'b1;
      end
      HOLD: begin
        if (!stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // store lane steering; low address bits beyond the access size are ignored
  always_comb begin
    be_c    = 4'h0;
    wdata_c = '0;
    case (ex_q.aux.funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ex_q.res[1:0];
        wdata_c = {4{ex_q.aux.wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {ex_q.res[1], 1'b0};
        wdata_c = {2{ex_q.aux.wdata[15:0]}};
      end
      default: begin
        be_c    = 4'hF;
        wdata_c = ex_q.aux.wdata;
      end
    endcase
  end

  assign dmem_we    = dmem_req & ex_q.aux.memWr;
  assign dmem_addr  = dmem_req ? {ex_q.res[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be_c : 4'h0;
  assign dmem_wdata = dmem_we ? wdata_c : '0;

  // load alignment and extension
  assign raw = (state_q == HOLD) ? load_q : dmem_rdata;

  always_comb begin
    byte_sel = raw[7:0];
    case (ex_q.res[1:0])
      2'b00:   byte_sel = raw[7:0];
      2'b01:   byte_sel = raw[15:8];
      2'b10:   byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  assign half_sel = ex_q.res[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    load_res = '0;
    case (ex_q.aux.funct3)
      3'b000:  load_res = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_res = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_res = raw;
      3'b100:  load_res = {24'h0, byte_sel};
      3'b101:  load_res = {16'h0, half_sel};
      default: load_res = '0;
    endcase
  end

  always_comb begin
    mem2wb_o             = '0;
    mem2wb_o.pc          = ex_q.pc;
    mem2wb_o.inst32      = ex_q.inst32;
    mem2wb_o.instValid   = ex_q.instValid;
    mem2wb_o.destReg     = (ex_q.aux.memWr | fault) ? 5'd0 : ex_q.destReg;
    mem2wb_o.res         = (memop & ex_q.aux.memRd) ? load_res : ex_q.res;
    mem2wb_o.excMisalign = fault;
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; checks follow AKARIN_MISALIGN_TRAP_EN when defined.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk, rst, ext_stall, stall, mem_stall;
  logic        req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  ex2memPkt    ex;
  mem2wbPkt    wb;
  int          total = 0;
  int          bad = 0;

  assign stall = ext_stall | mem_stall;

  mem_access dut (
    .clk(clk), .rst(rst), .stall_i(stall), .ex2mem_i(ex), .mem2wb_o(wb),
    .mem_stall_o(mem_stall), .dmem_req(req), .dmem_we(we), .dmem_addr(addr),
    .dmem_be(be), .dmem_wdata(wdata), .dmem_ack(ack), .dmem_rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic ex2memPkt mk(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] res, input logic [4:0] dest,
                                  input logic [31:0] wd);
    ex2memPkt p;
    p = '0;
    p.pc          = 32'h0000_1000 + res;
    p.inst32      = 32'h0000_0013;
    p.instValid   = 1'b1;
    p.destReg     = dest;
    p.res         = res;
    p.aux.memRd   = rd;
    p.aux.memWr   = wr;
    p.aux.funct3  = f3;
    p.aux.wdata   = wd;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // present a packet, let it enter the input register, then queue a bubble behind it
  task automatic load_pkt(input ex2memPkt p);
    ex = p;
    @(posedge clk); #1;
    ex = '0;
  endtask

  task automatic zero_wait(input logic [31:0] rd);
    rdata = rd;
    ack   = 1'b1;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 0; ext_stall = 0; ack = 0; rdata = '0; ex = '0;
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb.instValid), 32'd0);
    chk("rst_wb_res", wb.res, 32'd0);
    chk("rst_wb_pc", wb.pc, 32'd0);
    @(negedge clk); rst = 1;

    // plain ALU result passes through
    load_pkt(mk(1'b0, 1'b0, 3'b000, 32'h1234_5678, 5'd5, 32'h0));
    #1;
    chk("alu_res", wb.res, 32'h1234_5678);
    chk("alu_dest", 32'(wb.destReg), 32'd5);
    chk("alu_valid", 32'(wb.instValid), 32'd1);
    chk("alu_req", 32'(req), 32'd0);
    chk("alu_stall", 32'(mem_stall), 32'd0);

    // LB 0x103, zero-wait
    load_pkt(mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 5'd7, 32'h0));
    zero_wait(32'h80FF_FF00);
    chk("lb_req", 32'(req), 32'd1);
    chk("lb_addr", addr, 32'h0000_0100);
    chk("lb_we", 32'(we), 32'd0);
    chk("lb_stall", 32'(mem_stall), 32'd0);
    chk("lb_res", wb.res, 32'hFFFF_FF80);
    chk("lb_dest", 32'(wb.destReg), 32'd7);
    finish_cycle();

    // LHU 0x102, ack after three stall cycles
    load_pkt(mk(1'b1, 1'b0, 3'b101, 32'h0000_0102, 5'd9, 32'h0));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lhu_wait_req", 32'(req), 32'd1);
      chk("lhu_wait_stall", 32'(mem_stall), 32'd1);
      chk("lhu_wait_addr", addr, 32'h0000_0100);
      @(posedge clk); #1;
    end
    zero_wait(32'hBEEF_1234);
    chk("lhu_ack_stall", 32'(mem_stall), 32'd0);
    chk("lhu_res", wb.res, 32'h0000_BEEF);
    chk("lhu_dest", 32'(wb.destReg), 32'd9);
    finish_cycle();
    #1;
    chk("lhu_after_req", 32'(req), 32'd0);

    // SB 0x201
    load_pkt(mk(1'b0, 1'b1, 3'b000, 32'h0000_0201, 5'd3, 32'h0000_00AB));
    zero_wait(32'h0);
    chk("sb_req", 32'(req), 32'd1);
    chk("sb_we", 32'(we), 32'd1);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wdata, 32'hABAB_ABAB);
    chk("sb_addr", addr, 32'h0000_0200);
    chk("sb_dest", 32'(wb.destReg), 32'd0);
    finish_cycle();

    // SH 0x202
    load_pkt(mk(1'b0, 1'b1, 3'b001, 32'h0000_0202, 5'd3, 32'h5555_1234));
    zero_wait(32'h0);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wdata, 32'h1234_1234);
    finish_cycle();

    // LH sign extension, LBU zero extension, undefined funct3
    load_pkt(mk(1'b1, 1'b0, 3'b001, 32'h0000_0100, 5'd1, 32'h0));
    zero_wait(32'h0000_8001);
    chk("lh_res", wb.res, 32'hFFFF_8001);
    finish_cycle();
    load_pkt(mk(1'b1, 1'b0, 3'b100, 32'h0000_0102, 5'd1, 32'h0));
    zero_wait(32'h00AB_0000);
    chk("lbu_res", wb.res, 32'h0000_00AB);
    finish_cycle();
    load_pkt(mk(1'b1, 1'b0, 3'b011, 32'h0000_0100, 5'd1, 32'h0));
    zero_wait(32'hFFFF_FFFF);
    chk("f3_bad_res", wb.res, 32'h0);
    finish_cycle();

    // ack together with external stall: HOLD serves load_q, no reissue
    load_pkt(mk(1'b1, 1'b0, 3'b010, 32'h0000_0300, 5'd4, 32'h0));
    ext_stall = 1'b1;
    zero_wait(32'hCAFE_F00D);
    chk("hold_ack_req", 32'(req), 32'd1);
    chk("hold_ack_stall", 32'(mem_stall), 32'd0);
    chk("hold_ack_res", wb.res, 32'hCAFE_F00D);
    for (int i = 0; i < 2; i++) begin
      finish_cycle();
      rdata = 32'hDEAD_BEEF;
      #1;
      chk("hold_req", 32'(req), 32'd0);
      chk("hold_res", wb.res, 32'hCAFE_F00D);
      chk("hold_dest", 32'(wb.destReg), 32'd4);
      chk("hold_mstall", 32'(mem_stall), 32'd0);
    end
    ext_stall = 1'b0;
    @(posedge clk); #1;
    chk("hold_exit_req", 32'(req), 32'd0);
    chk("hold_exit_valid", 32'(wb.instValid), 32'd0);

    // LW at 0x2
    load_pkt(mk(1'b1, 1'b0, 3'b010, 32'h0000_0002, 5'd6, 32'h0));
`ifdef AKARIN_MISALIGN_TRAP_EN
    #1;
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_exc", 32'(wb.excMisalign), 32'd1);
    chk("mis_dest", 32'(wb.destReg), 32'd0);
    chk("mis_res", wb.res, 32'h0000_0002);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
`else
    zero_wait(32'h1122_3344);
    chk("mis_req", 32'(req), 32'd1);
    chk("mis_addr", addr, 32'h0);
    chk("mis_be", 32'(be), 32'hF);
    chk("mis_res", wb.res, 32'h1122_3344);
    chk("mis_exc", 32'(wb.excMisalign), 32'd0);
    finish_cycle();
`endif

    // reset while BUSY, then a stray ack
    load_pkt(mk(1'b1, 1'b0, 3'b010, 32'h0000_0400, 5'd8, 32'h0));
    #1;
    chk("busy_pre_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    chk("busy_req", 32'(req), 32'd1);
    chk("busy_stall", 32'(mem_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstbusy_req", 32'(req), 32'd0);
    chk("rstbusy_valid", 32'(wb.instValid), 32'd0);
    chk("rstbusy_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rdata = 32'h7777_7777;
    ack   = 1'b1;
    #1;
    chk("stray_req", 32'(req), 32'd0);
    chk("stray_valid", 32'(wb.instValid), 32'd0);
    chk("stray_stall", 32'(mem_stall), 32'd0);
    finish_cycle();
    #1;
    chk("stray_after_req", 32'(req), 32'd0);
    chk("stray_after_valid", 32'(wb.instValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
